// File: rtl/rf_pkg.sv
// Constants shared by the register file and every writer of it.
// ZERO_REG reads as zero and silently drops writes.
package rf_pkg;

  localparam int WIDTH = 64;
  localparam int AW    = 5;

  localparam logic [AW-1:0] ZERO_REG = 5'd31;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue with wrap-bit pointers; exposes the raw entry array
// and the read index so the owner can search queued contents.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 69
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DW-1:0]                 din,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DW-1:0]                 head,
  output logic [$clog2(DEPTH)-1:0]      rd_idx,
  output logic [DEPTH-1:0][DW-1:0]      entries
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = 1;
  localparam logic [PW:0] CAP = DEPTH;

  logic [PW:0]               wptr_q, wptr_d;
  logic [PW:0]               rptr_q, rptr_d;
  logic [DEPTH-1:0][DW-1:0]  mem_q, mem_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (push) begin
      mem_d[wptr_q[PW-1:0]] = din;
      wptr_d = wptr_q + ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

  assign count   = wptr_q - rptr_q;
  assign full    = (count == CAP);
  assign empty   = (count == '0);
  assign head    = mem_q[rptr_q[PW-1:0]];
  assign rd_idx  = rptr_q[PW-1:0];
  assign entries = mem_q;

endmodule

// File: rtl/writeback_buffer.sv
// Queues writebacks for the register file write port, draining one per
// clock, and forwards still-pending values onto the operand read buses.
module writeback_buffer
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = rf_pkg::WIDTH,
  parameter int AW    = rf_pkg::AW
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [AW-1:0]          InRd,
  input  logic [WIDTH-1:0]       InData,
  output logic [AW-1:0]          RW,
  output logic [WIDTH-1:0]       BusW,
  output logic                   RegWr,
  input  logic [AW-1:0]          RA,
  input  logic [AW-1:0]          RB,
  input  logic [WIDTH-1:0]       BusAIn,
  input  logic [WIDTH-1:0]       BusBIn,
  output logic [WIDTH-1:0]       BusAOut,
  output logic [WIDTH-1:0]       BusBOut,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = AW + WIDTH;
  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic                     full, empty;
  logic                     push, pop;
  logic [CW-1:0]            count;
  logic [DW-1:0]            head;
  logic [PW-1:0]            rd_idx;
  logic [DEPTH-1:0][DW-1:0] entries;

  logic             regwr_q, regwr_d;
  logic [AW-1:0]    rw_q, rw_d;
  logic [WIDTH-1:0] busw_q, busw_d;

  assign InReady = !Reset && !full;
  assign push    = InValid && InReady && (InRd != ZR);
  assign pop     = !empty;

  wb_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (Clk),
    .rst     (Reset),
    .push    (push),
    .pop     (pop),
    .din     ({InRd, InData}),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .head    (head),
    .rd_idx  (rd_idx),
    .entries (entries)
  );

  always_comb begin
    regwr_d = pop;
    rw_d    = rw_q;
    busw_d  = busw_q;
    if (pop) begin
      rw_d   = head[DW-1:WIDTH];
      busw_d = head[WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      regwr_q <= 1'b0;
      rw_q    <= '0;
      busw_q  <= '0;
    end else begin
      regwr_q <= regwr_d;
      rw_q    <= rw_d;
      busw_q  <= busw_d;
    end
  end

  // Scan oldest to youngest so the youngest match is left standing.
  function automatic logic [WIDTH-1:0] bypass(
    input logic [AW-1:0]    ra,
    input logic [WIDTH-1:0] raw
  );
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    k;
    logic [PW-1:0]    slot;
    r = raw;
    if (regwr_q && rw_q == ra) r = busw_q;
    for (int i = 0; i < DEPTH; i++) begin
      k    = CW'(i);
      slot = rd_idx + k[PW-1:0];
      if (k < count && entries[slot][DW-1:WIDTH] == ra)
        r = entries[slot][WIDTH-1:0];
    end
    if (ra == ZR) r = '0;
    return r;
  endfunction

  always_comb begin
    BusAOut = bypass(RA, BusAIn);
    BusBOut = bypass(RB, BusBIn);
  end

  assign RW    = rw_q;
  assign BusW  = busw_q;
  assign RegWr = regwr_q;
  assign Count = count;

endmodule

// File: tb/tb_writeback_buffer.sv
// Randomised and directed bench for writeback_buffer against a
// queue-based model plus a bench-owned register file.
module tb_writeback_buffer;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset, InValid, InReady, RegWr;
  logic [4:0]  InRd, RW, RA, RB;
  logic [63:0] InData, BusW, BusAIn, BusBIn, BusAOut, BusBOut;
  logic [2:0]  Count;

  writeback_buffer #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InRd(InRd), .InData(InData), .RW(RW), .BusW(BusW), .RegWr(RegWr),
    .RA(RA), .RB(RB), .BusAIn(BusAIn), .BusBIn(BusBIn),
    .BusAOut(BusAOut), .BusBOut(BusBOut), .Count(Count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic        m_regwr;
  logic [4:0]  m_rw;
  logic [63:0] m_busw;
  logic [63:0] rf[32];

  int vectors = 0;
  int miscompares = 0;

  logic        act_ready, exp_ready;
  logic [63:0] act_a, exp_a, act_b, exp_b;

  function automatic logic [63:0] ref_read(input logic [4:0] r);
    if (r == 5'd31) return 64'd0;
    for (int i = m_q.size() - 1; i >= 0; i--)
      if (m_q[i].rd == r) return m_q[i].data;
    if (m_regwr && m_rw == r) return m_busw;
    return rf[r];
  endfunction

  task automatic step(input logic rst, input logic v,
                      input logic [4:0] rd, input logic [63:0] d,
                      input logic [4:0] ra, input logic [4:0] rb);
    @(negedge Clk);
    if (m_regwr) rf[m_rw] = m_busw;
    Reset = rst; InValid = v; InRd = rd; InData = d;
    RA = ra; RB = rb; BusAIn = rf[ra]; BusBIn = rf[rb];
    #1;
    exp_ready = !rst && (m_q.size() < DEPTH);
    exp_a = ref_read(ra);
    exp_b = ref_read(rb);
    act_ready = InReady; act_a = BusAOut; act_b = BusBOut;
    @(posedge Clk);
    if (rst) begin
      m_q.delete();
      m_regwr = 1'b0; m_rw = '0; m_busw = '0;
    end else begin
      bit acc;
      acc = v && (m_q.size() < DEPTH);
      if (m_q.size() > 0) begin
        m_regwr = 1'b1;
        m_rw = m_q[0].rd;
        m_busw = m_q[0].data;
        void'(m_q.pop_front());
      end else begin
        m_regwr = 1'b0;
      end
      if (acc && rd != 5'd31) m_q.push_back('{rd, d});
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
    step(1'b1, 1'b1, 5'd4, 64'd7, 5'd1, 5'd2);
    vectors++;
    if ({RegWr, RW, BusW, Count} !== {1'b0, 5'd0, 64'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_state got %b/%0d/%h/%0d want 0/0/0/0",
               RegWr, RW, BusW, Count);
    end
    vectors++;
    if (act_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready got %b want 0", act_ready);
    end
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    vectors++;
    if (act_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_ready got %b want 1", act_ready);
    end
  endtask

  task automatic test_single_write();
    step(1'b0, 1'b1, 5'd5, 64'hAA, 5'd5, 5'd0);
    vectors++;
    if ({RegWr, Count} !== {1'b0, 3'd1}) begin
      miscompares++;
      $display("FAIL single_accept got RegWr=%b Count=%0d want 0/1",
               RegWr, Count);
    end
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd0);
    vectors++;
    if (act_a !== 64'hAA) begin
      miscompares++;
      $display("FAIL single_bypass got %h want aa", act_a);
    end
    vectors++;
    if ({RegWr, RW, BusW, Count} !== {1'b1, 5'd5, 64'hAA, 3'd0}) begin
      miscompares++;
      $display("FAIL single_drain got %b/%0d/%h/%0d want 1/5/aa/0",
               RegWr, RW, BusW, Count);
    end
  endtask

  task automatic test_back_to_back();
    logic [68:0] log_q[$];
    logic [68:0] want;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, i < 5, 5'(i + 1), 64'h100 + 64'(i), 5'(i), 5'(i + 1));
      if (RegWr) log_q.push_back({RW, BusW});
      vectors++;
      if (Count > 3'(DEPTH) || act_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL b2b_level cyc %0d got Count=%0d rdy=%b want rdy=%b",
                 i, Count, act_ready, exp_ready);
      end
      vectors++;
      if ({RegWr, RW, BusW, Count} !==
          {m_regwr, m_rw, m_busw, 3'(m_q.size())}) begin
        miscompares++;
        $display("FAIL b2b_state cyc %0d got %b/%0d/%h/%0d want %b/%0d/%h/%0d",
                 i, RegWr, RW, BusW, Count,
                 m_regwr, m_rw, m_busw, m_q.size());
      end
    end
    vectors++;
    if (log_q.size() != 5) begin
      miscompares++;
      $display("FAIL b2b_count got %0d writes want 5", log_q.size());
    end
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      want = {5'(i + 1), 64'h100 + 64'(i)};
      vectors++;
      if (log_q[i] !== want) begin
        miscompares++;
        $display("FAIL b2b_order %0d got %h want %h", i, log_q[i], want);
      end
    end
  endtask

  task automatic test_xzr();
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd31, 64'h55, 5'd31, 5'd31);
    vectors++;
    if ({act_a, act_b} !== 128'd0 || act_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL xzr_read got a=%h b=%h rdy=%b want 0/0/1",
               act_a, act_b, act_ready);
    end
    vectors++;
    if (Count !== 3'd0) begin
      miscompares++;
      $display("FAIL xzr_count got %0d want 0", Count);
    end
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd31, 5'd0);
    vectors++;
    if (RegWr !== 1'b0) begin
      miscompares++;
      $display("FAIL xzr_write got RegWr=%b RW=%0d want RegWr=0",
               RegWr, RW);
    end
  endtask

  task automatic test_bypass();
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    rf[3] = 64'h9;
    step(1'b0, 1'b1, 5'd3, 64'h1, 5'd3, 5'd3);
    vectors++;
    if (act_a !== 64'h9) begin
      miscompares++;
      $display("FAIL byp_raw got %h want 9", act_a);
    end
    step(1'b0, 1'b1, 5'd3, 64'h2, 5'd3, 5'd3);
    vectors++;
    if (act_a !== 64'h1) begin
      miscompares++;
      $display("FAIL byp_q1 got %h want 1", act_a);
    end
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd3);
    vectors++;
    if (act_a !== 64'h2 || act_b !== 64'h2) begin
      miscompares++;
      $display("FAIL byp_young got a=%h b=%h want 2/2", act_a, act_b);
    end
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd3);
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd3);
    vectors++;
    if (act_a !== 64'h2 || RegWr !== 1'b0) begin
      miscompares++;
      $display("FAIL byp_rf got a=%h RegWr=%b want 2/0", act_a, RegWr);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 5'(10 + i), 64'hC0 + 64'(i), 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd12, 5'd11);
    vectors++;
    if ({RegWr, RW, BusW, Count} !== {1'b0, 5'd0, 64'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL rst_mid got %b/%0d/%h/%0d want 0/0/0/0",
               RegWr, RW, BusW, Count);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 5'd0, 64'd0, 5'd12, 5'd11);
      vectors++;
      if (RegWr !== 1'b0 || act_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_after cyc %0d got RegWr=%b rdy=%b want 0/1",
                 i, RegWr, act_ready);
      end
    end
  endtask

  task automatic test_random();
    logic       rst, v;
    logic [4:0] rd, ra, rb;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      rb  = 5'($urandom_range(0, 7));
      step(rst, v, rd, {$urandom, $urandom}, ra, rb);
      vectors++;
      if ({act_ready, act_a, act_b} !== {exp_ready, exp_a, exp_b}) begin
        miscompares++;
        $display("FAIL rnd_comb cyc %0d got %b/%h/%h want %b/%h/%h",
                 i, act_ready, act_a, act_b, exp_ready, exp_a, exp_b);
      end
      vectors++;
      if ({RegWr, RW, BusW, Count} !==
          {m_regwr, m_rw, m_busw, 3'(m_q.size())}) begin
        miscompares++;
        $display("FAIL rnd_state cyc %0d got %b/%0d/%h/%0d want %b/%0d/%h/%0d",
                 i, RegWr, RW, BusW, Count,
                 m_regwr, m_rw, m_busw, m_q.size());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; InValid = 1'b0; InRd = '0; InData = '0;
    RA = '0; RB = '0; BusAIn = '0; BusBIn = '0;
    m_regwr = 1'b0; m_rw = '0; m_busw = '0;
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    test_reset();
    test_single_write();
    test_back_to_back();
    test_xzr();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
